matrix_result_collector: RTL and testbench

- Responder for the multiplier's result interface: accepts each (z_i, z_j, z_in) beat under z_stb/z_ack and stores it in an m×m register array.
- Supplies current_element, the stored partial sum for the element being accumulated, back to the multiplier.
- Exposes a registered random-access read port for the host once the multiplier signals done.
- Sits between sequential_matrix_multiplier and the host/testbench readout.

---
 rtl/matrix_result_collector_if.sv | 38 +++
 rtl/matrix_result_collector.sv | 174 +++++++++++++++++
 tb/tb_matrix_result_collector.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_collector_if.sv
// -----------------------------------------------------------------------------
// matrix_result_collector_if
//
// Result-beat bus between the sequential matrix multiplier (master) and the
// result collector (slave). Each beat carries one partial sum for element
// (z_i, z_j). The bus uses a four-phase z_stb/z_ack handshake. The collector
// also returns the partial sum it currently holds for (z_i, z_j).
//
// Signals:
//   z_in             master -> slave  DATA_W  partial-sum bit pattern
//   z_i, z_j         master -> slave  m_len   element row / column
//   z_stb            master -> slave  1       beat valid
//   z_ack            slave  -> master 1       beat accepted (registered)
//   current_element  slave  -> master DATA_W  stored value at (z_i, z_j)
// -----------------------------------------------------------------------------
interface matrix_result_collector_if #(
   parameter int m      = 4,
   parameter int DATA_W = 32
);
   localparam int m_len = $clog2(m);

   logic [DATA_W-1:0] z_in;
   logic [m_len-1:0]  z_i;
   logic [m_len-1:0]  z_j;
   logic              z_stb;
   logic              z_ack;
   logic [DATA_W-1:0] current_element;

   modport master (
      output z_in, z_i, z_j, z_stb,
      input  z_ack, current_element
   );

   modport slave (
      input  z_in, z_i, z_j, z_stb,
      output z_ack, current_element
   );
endinterface

// File: rtl/matrix_result_collector.sv
// -----------------------------------------------------------------------------
// matrix_result_collector
//
// Stores the multiplier's result beats in an m x m register array. It returns
// the stored partial sum for the element being accumulated, and offers a
// registered random-access read port to the host. Element values are opaque
// bit patterns and are never interpreted arithmetically.
//
// Optional feature: define MATRIX_COLLECTOR_WR_COUNT_EN to build the
// accepted-beat counter. When the macro is undefined, wr_count is tied to 0.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   z_bus         slave modport of matrix_result_collector_if (result beats)
//   mult_done     in   one-cycle pulse: the multiplier has finished a run
//   clear         in   synchronous clear of array and status (level-sampled)
//   matrix_valid  out  results complete; high from the cycle after mult_done
//   rd_en         in   host read request
//   rd_i, rd_j    in   host read address
//   rd_data       out  read data, one cycle after rd_en
//   rd_valid      out  high in the cycle rd_data was updated
//   wr_count      out  accepted-beat count, saturating at m*m*m
// -----------------------------------------------------------------------------
module matrix_result_collector #(
   parameter  int m      = 4,
   parameter  int DATA_W = 32,
   localparam int m_len  = $clog2(m),
   localparam int CNT_W  = $clog2(m*m*m+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   matrix_result_collector_if.slave z_bus,
   input  logic                  mult_done,
   input  logic                  clear,
   output logic                  matrix_valid,
   input  logic                  rd_en,
   input  logic [m_len-1:0]      rd_i,
   input  logic [m_len-1:0]      rd_j,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic [CNT_W-1:0]      wr_count
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   // The extra index bit lets the bound m itself be expressed when m is a
   // power of two.
   localparam logic [m_len:0] IDX_LIM = (m_len+1)'(m);

   state_t            state, state_nxt;
   logic              z_ack_q, ack_nxt;
   logic              do_accept;   // beat taken this cycle (one per handshake)
   logic              do_clear;    // clear honoured (only in S_IDLE)
   logic              z_in_range, rd_in_range;
   logic [DATA_W-1:0] mem [m][m];

   // If m is not a power of two, the index fields can encode addresses
   // outside the array. Such beats are acknowledged but not stored.
   assign z_in_range  = ({1'b0, z_bus.z_i} < IDX_LIM) && ({1'b0, z_bus.z_j} < IDX_LIM);
   assign rd_in_range = ({1'b0, rd_i} < IDX_LIM) && ({1'b0, rd_j} < IDX_LIM);

   // ---------------- handshake FSM ----------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         z_ack_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         z_ack_q <= ack_nxt;
      end
   end

   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      ack_nxt   = z_ack_q;
      do_accept = 1'b0;
      do_clear  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (clear) begin
               // clear wins; a simultaneous beat waits for the next cycle
               do_clear = 1'b1;
            end else if (z_bus.z_stb) begin
               do_accept = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            // Any clear waits here until the handshake closes.
            if (!z_bus.z_stb) begin
               ack_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            ack_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign z_bus.z_ack = z_ack_q;

   // ---------------- result array ----------------
   // NOTE: this array is reset (and cleared) on purpose, because readers rely
   // on zeroed entries; storage arrays normally get no reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
               mem[r][c] <= '0;
      end else if (do_clear) begin
         for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
               mem[r][c] <= '0;
      end else if (do_accept && z_in_range) begin
         mem[z_bus.z_i][z_bus.z_j] <= z_bus.z_in;
      end
   end

   assign z_bus.current_element = z_in_range ? mem[z_bus.z_i][z_bus.z_j] : '0;

   // ---------------- host read port ----------------
   // A read in the same cycle as a write to that address returns the old
   // value, because mem updates on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= rd_in_range ? mem[rd_i][rd_j] : '0;
      end
   end

   // ---------------- status ----------------
   // Priority: clear, then done, then a new beat (which starts a new run).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         matrix_valid <= 1'b0;
      else if (do_clear)
         matrix_valid <= 1'b0;
      else if (mult_done)
         matrix_valid <= 1'b1;
      else if (do_accept)
         matrix_valid <= 1'b0;
   end

`ifdef MATRIX_COLLECTOR_WR_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(m*m*m);
   logic [CNT_W-1:0] wr_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wr_count_q <= '0;
      else if (do_clear)
         wr_count_q <= '0;
      else if (do_accept && (wr_count_q != CNT_MAX))
         wr_count_q <= wr_count_q + 1'b1;
   end

   assign wr_count = wr_count_q;
`else
   assign wr_count = '0;
`endif

endmodule

// File: tb/tb_matrix_result_collector.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_collector
//
// Self-checking bench for matrix_result_collector (m=4, DATA_W=32). Stimulus
// is driven one time unit after each rising edge, and results are sampled at
// that same point.
// -----------------------------------------------------------------------------
module tb_matrix_result_collector;

   localparam int M  = 4;
   localparam int DW = 32;
   localparam int ML = $clog2(M);
   localparam int CW = $clog2(M*M*M+1);

   logic            clk = 1'b0;
   logic            rst;
   logic            mult_done, clear, rd_en;
   logic [ML-1:0]   rd_i, rd_j;
   logic [DW-1:0]   rd_data;
   logic            rd_valid, matrix_valid;
   logic [CW-1:0]   wr_count;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   matrix_result_collector_if #(.m(M), .DATA_W(DW)) zb ();

   matrix_result_collector #(.m(M), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .z_bus        (zb.slave),
      .mult_done    (mult_done),
      .clear        (clear),
      .matrix_valid (matrix_valid),
      .rd_en        (rd_en),
      .rd_i         (rd_i),
      .rd_j         (rd_j),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .wr_count     (wr_count)
   );

   typedef struct {
      logic [ML-1:0] wi, wj;
      logic [DW-1:0] wd;
      logic [ML-1:0] ri, rj;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_wr();
`ifdef MATRIX_COLLECTOR_WR_COUNT_EN
      return exp_cnt;
`else
      return 32'd0;
`endif
   endfunction

   function automatic void count_beat();
      exp_cnt = (exp_cnt < M*M*M) ? exp_cnt + 1 : M*M*M;
   endfunction

   // Single-precision bit pattern of a small non-negative integer.
   function automatic logic [31:0] fl(input int n);
      int e;
      if (n == 0) return 32'h0;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7FFFFF)};
   endfunction

   // One full handshake. z_stb stays high for 'hold' cycles after the accept.
   // While z_stb is held, z_in is corrupted so that any extra write is visible.
   task automatic beat(input logic [ML-1:0] i, input logic [ML-1:0] j,
                       input logic [DW-1:0] d, input int hold, input string name);
      zb.z_i   = i;
      zb.z_j   = j;
      zb.z_in  = d;
      zb.z_stb = 1'b1;
      tick;
      count_beat();
      check({name, " ack rise"}, 32'(zb.z_ack), 32'd1);
      for (int h = 1; h < hold; h++) begin
         zb.z_in = ~d;
         tick;
         check({name, " ack hold"}, 32'(zb.z_ack), 32'd1);
      end
      zb.z_stb = 1'b0;
      tick;
      check({name, " ack fall"}, 32'(zb.z_ack), 32'd0);
      check({name, " cur elem"}, zb.current_element, d);
   endtask

   task automatic rd(input logic [ML-1:0] i, input logic [ML-1:0] j,
                     input logic [DW-1:0] exp, input string name);
      rd_en = 1'b1;
      rd_i  = i;
      rd_j  = j;
      tick;
      rd_en = 1'b0;
      check({name, " rd_valid"}, 32'(rd_valid), 32'd1);
      check({name, " rd_data"}, rd_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      mult_done = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_i = '0; rd_j = '0;
      zb.z_in = '0; zb.z_i = '0; zb.z_j = '0; zb.z_stb = 1'b0;

      tbl[0] = '{2'd0, 2'd1, 32'h40800000, 2'd0, 2'd1, 32'h40800000};
      tbl[1] = '{2'd3, 2'd0, 32'h40E00000, 2'd0, 2'd1, 32'h40800000};
      tbl[2] = '{2'd0, 2'd1, 32'h41000000, 2'd0, 2'd1, 32'h41000000};
      tbl[3] = '{2'd2, 2'd3, 32'h41100000, 2'd3, 2'd3, 32'hDEADBEEF};
      tbl[4] = '{2'd1, 2'd0, 32'h3F000000, 2'd3, 2'd0, 32'h40E00000};
      tbl[5] = '{2'd3, 2'd3, 32'h00000001, 2'd2, 2'd3, 32'h41100000};

      // ---- reset state ----
      #22 rst = 1'b1;
      tick;
      check("rst z_ack", 32'(zb.z_ack), 32'd0);
      check("rst matrix_valid", 32'(matrix_valid), 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      check("rst rd_valid", 32'(rd_valid), 32'd0);
      check("rst wr_count", 32'(wr_count), 32'd0);
      check("rst cur elem", zb.current_element, 32'd0);

      // ---- T1: held strobe writes exactly once ----
      beat(2'd1, 2'd2, 32'h3F800000, 3, "t1");
      check("t1 wr_count", 32'(wr_count), exp_wr());
      rd(2'd1, 2'd2, 32'h3F800000, "t1 read");

      // ---- T2: back-to-back beats to (0,0) ----
      beat(2'd0, 2'd0, 32'h40000000, 1, "t2a");
      beat(2'd0, 2'd0, 32'h40400000, 1, "t2b");
      rd(2'd0, 2'd0, 32'h40400000, "t2 read");
      tick;
      check("t2 rd_valid drop", 32'(rd_valid), 32'd0);
      check("t2 rd_data hold", rd_data, 32'h40400000);

      // ---- clear in S_ACK waits until S_IDLE ----
      zb.z_i = 2'd1; zb.z_j = 2'd1; zb.z_in = 32'h40A00000; zb.z_stb = 1'b1;
      tick;
      count_beat();
      check("dc ack", 32'(zb.z_ack), 32'd1);
      clear = 1'b1;
      tick;
      check("dc ack held", 32'(zb.z_ack), 32'd1);
      check("dc not cleared 1", zb.current_element, 32'h40A00000);
      zb.z_stb = 1'b0;
      tick;
      check("dc ack fall", 32'(zb.z_ack), 32'd0);
      check("dc not cleared 2", zb.current_element, 32'h40A00000);
      tick;
      clear = 1'b0;
      exp_cnt = 0;
      check("dc cleared", zb.current_element, 32'd0);
      check("dc wr_count", 32'(wr_count), exp_wr());

      // ---- T3: clear and strobe together in S_IDLE ----
      beat(2'd1, 2'd2, 32'h3F800000, 1, "t3 pre");
      zb.z_i = 2'd3; zb.z_j = 2'd3; zb.z_in = 32'hDEADBEEF; zb.z_stb = 1'b1;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      exp_cnt = 0;
      check("t3 no ack on clear", 32'(zb.z_ack), 32'd0);
      check("t3 wr_count cleared", 32'(wr_count), exp_wr());
      tick;
      count_beat();
      check("t3 ack after clear", 32'(zb.z_ack), 32'd1);
      check("t3 cur elem", zb.current_element, 32'hDEADBEEF);
      zb.z_stb = 1'b0;
      tick;
      check("t3 ack fall", 32'(zb.z_ack), 32'd0);
      check("t3 wr_count", 32'(wr_count), exp_wr());
      rd(2'd1, 2'd2, 32'd0, "t3 zeroed");
      rd(2'd3, 2'd3, 32'hDEADBEEF, "t3 read");

      // ---- table-driven write/read vectors ----
      for (int v = 0; v < 6; v++) begin
         beat(tbl[v].wi, tbl[v].wj, tbl[v].wd, 1, $sformatf("tbl%0d", v));
         rd(tbl[v].ri, tbl[v].rj, tbl[v].exp_rd, $sformatf("tbl%0d read", v));
      end

      // ---- T6: read and write to the same address in one cycle ----
      zb.z_i = 2'd2; zb.z_j = 2'd1; zb.z_in = 32'h41200000; zb.z_stb = 1'b1;
      rd_en = 1'b1; rd_i = 2'd2; rd_j = 2'd1;
      tick;
      count_beat();
      check("t6 ack", 32'(zb.z_ack), 32'd1);
      check("t6 rd_valid", 32'(rd_valid), 32'd1);
      check("t6 old value", rd_data, 32'd0);
      tick;
      rd_en = 1'b0;
      check("t6 new value", rd_data, 32'h41200000);
      zb.z_stb = 1'b0;
      tick;
      check("t6 ack fall", 32'(zb.z_ack), 32'd0);

      // ---- matrix_valid set and clear priority ----
      mult_done = 1'b1;
      tick;
      mult_done = 1'b0;
      check("mv set", 32'(matrix_valid), 32'd1);
      tick;
      check("mv hold", 32'(matrix_valid), 32'd1);
      clear = 1'b1; mult_done = 1'b1;
      tick;
      clear = 1'b0; mult_done = 1'b0;
      exp_cnt = 0;
      check("mv clear priority", 32'(matrix_valid), 32'd0);
      check("mv wr_count", 32'(wr_count), exp_wr());

      // ---- T4: full 4x4x4 run, A = identity, B[i][j] = i*4+j ----
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < M; j++) begin
            for (int k = 0; k < M; k++) begin
               logic [31:0] partial;
               partial = (k > i) ? fl(i*4 + j) : 32'd0;
               zb.z_i = ML'(i); zb.z_j = ML'(j);
               #1;
               check($sformatf("t4 cur %0d%0d%0d", i, j, k), zb.current_element, partial);
               beat(ML'(i), ML'(j), (k == i) ? fl(i*4 + j) : partial, 1,
                    $sformatf("t4 beat %0d%0d%0d", i, j, k));
            end
         end
      end
      mult_done = 1'b1;
      tick;
      mult_done = 1'b0;
      check("t4 matrix_valid", 32'(matrix_valid), 32'd1);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            rd(ML'(i), ML'(j), fl(i*4 + j), $sformatf("t4 read %0d%0d", i, j));
      check("t4 wr_count", 32'(wr_count), exp_wr());

      // A new beat after done starts a new run. The count must saturate.
      beat(2'd0, 2'd0, 32'd0, 1, "sat");
      check("sat matrix_valid drop", 32'(matrix_valid), 32'd0);
      check("sat wr_count", 32'(wr_count), exp_wr());

      // ---- T5: reset in the middle of a handshake ----
      zb.z_i = 2'd3; zb.z_j = 2'd2; zb.z_in = 32'h12345678; zb.z_stb = 1'b1;
      tick;
      check("t5 ack before rst", 32'(zb.z_ack), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t5 ack async drop", 32'(zb.z_ack), 32'd0);
      zb.z_stb = 1'b0;
      exp_cnt = 0;
      #10 rst = 1'b1;
      check("t5 wr_count", 32'(wr_count), exp_wr());
      check("t5 rd_valid", 32'(rd_valid), 32'd0);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            rd(ML'(i), ML'(j), 32'd0, $sformatf("t5 read %0d%0d", i, j));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
